alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one ALU operand path between two requesters using round-robin arbitration.
- Drives the select of a 32-bit 2:1 operand mux and issues a start pulse to the ALU.
- Waits a fixed ALU latency, captures the result and returns it with the requester id over a valid/ready response channel.
- Sits between the two operand sources (e.g. fetch/exec units) and the ALU.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ALU_LAT, 1, cycles from alu_start to a valid alu_result; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand; must hold valid and data until req0_ready.
- req0_data  in  WIDTH  requester 0 operand.
- req0_ready  out  1  transaction for requester 0 complete (one-cycle pulse).
- req1_valid, req1_data, req1_ready: same as requester 0, for requester 1.
- sel  out  1  operand mux select (0 = req0_data, 1 = req1_data).
- alu_in  out  WIDTH  mux output to the ALU.
- alu_start  out  1  one-cycle ALU start pulse.
- alu_result  in  WIDTH  ALU result.
- rsp_valid  out  1  response available.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  WIDTH  captured ALU result.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sel=0, last_grant=1, wait counter=0, rsp_data=0.
  - All of alu_start, rsp_valid, rsp_id, req0_ready, req1_ready and busy are 0.
  - Reset during any state aborts the transaction: no ready pulse and no response.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant !last_grant.
  - On grant, sel is registered and the FSM moves to ISSUE on the next edge.
  - No valid: stay in IDLE.
- ISSUE (1 cycle):
  - alu_start=1; alu_in = sel ? req1_data : req0_data.
  - Counter loads ALU_LAT; next state WAIT.
- WAIT:
  - alu_in is held by the mux because the requester holds its data; counter decrements each cycle.
  - On the edge where counter==1: rsp_data<=alu_result, rsp_id<=sel, next state RESP.
- RESP:
  - rsp_valid=1, held until rsp_ready.
  - When rsp_ready=1: reqN_ready=1 combinationally for the granted N only, last_grant<=sel, next state IDLE.
  - rsp_valid stays stable while stalled.
- Latency: grant at cycle T -> alu_start at T+1 -> rsp_valid from T+2+ALU_LAT.
  - With ALU_LAT=1, rsp_valid is first high at T+3.
  - Back-to-back throughput is one transaction per 3+ALU_LAT cycles with no stall.
- alu_start is never high outside ISSUE, and the two ready outputs are never high together.
- A new request arriving while busy is not sampled until IDLE.
- A requester dropping valid before ready is a protocol violation. The arbiter still completes the transaction and pulses ready.
- sel changes only on an IDLE grant edge or on reset.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...

Decomposition:
- Package alu_arb_pkg holds:
  - state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - default WIDTH and the counter width of 4 bits.
- Sub-module: the existing MUX2to1 instance (input0=req0_data, input1=req1_data, select=sel, out=alu_in).
- The FSM, counter and round-robin pointer stay in alu_share_arbiter.

Test Plan:
- Reset: hold rst_n=0 with both valid -> all outputs 0, sel=0. Release -> req0 granted first (last_grant=1).
- Single request: ALU stub result=in+1, ALU_LAT=2, req0_data=32'hAAAAAAAA.
  - alu_start at T+1 with alu_in=32'hAAAAAAAA.
  - rsp_valid at T+4 with rsp_data=32'hAAAAAAAB and rsp_id=0.
  - req0_ready pulses in the rsp_ready cycle.
- Contention: both valid continuously, req0=32'h55555555, req1=32'hDEADBEEF, rsp_ready=1.
  - Responses come out in order id 0,1,0,1 with data 32'h55555556, 32'hDEADBEF0.
  - sel toggles exactly at grants.
- Backpressure: rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_data and rsp_id stay stable; no ready pulse; busy=1.
  - Asserting rsp_ready completes the transaction in the same cycle.
- Reset mid-WAIT: assert rst_n=0 during WAIT.
  - Immediately rsp_valid=0, busy=0, no req_ready.
  - After release, a new request completes normally.
- ALU_LAT=1 and ALU_LAT=15 builds: rsp_valid is first high exactly at T+3 and T+17 respectively.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared constants and state encoding for the ALU operand-sharing arbiter.
package alu_arb_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_mux2to1.sv
// 2:1 operand mux feeding the shared ALU.
// Ports: input0/input1 - candidate operands; select - 0 picks input0, 1 picks input1;
//        out - selected operand.
module MUX2to1
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] input0,
  input  logic [WIDTH-1:0] input1,
  input  logic             select,
  output logic [WIDTH-1:0] out
);

  assign out = select ? input1 : input0;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU operand path between two requesters.
// Grants a requester, pulses alu_start, waits ALU_LAT cycles, captures the
// result and returns it with the owner id on a valid/ready response channel.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   reqN_valid/data/ready      - requester N operand handshake (ready is a 1-cycle pulse)
//   sel, alu_in, alu_start     - mux select, muxed operand, ALU start pulse
//   alu_result                 - ALU result, valid ALU_LAT cycles after alu_start
//   rsp_valid/id/data/ready    - response channel
//   busy                       - high whenever not idle
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sel,
  output logic [WIDTH-1:0] alu_in,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  arb_state_e       r_state;
  arb_state_e       w_next_state;
  logic             r_sel;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_id;
  logic             r_rsp_valid;
  logic             r_alu_start;
  logic             r_busy;

  logic             w_any_valid;
  logic             w_grant;
  logic             w_take_grant;
  logic             w_capture;
  logic             w_accept;

  // Round-robin: on contention the requester not served last wins.
  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

  // Operand mux; requester holds its data until ready, so alu_in stays stable.
  MUX2to1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .input0 (req0_data),
    .input1 (req1_data),
    .select (r_sel),
    .out    (alu_in)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control strobes.
  always_comb begin
    w_next_state = r_state;
    w_take_grant = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_take_grant = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_capture    = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_accept     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Grant pointer, latency counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
    end else begin
      if (w_take_grant) begin
        r_sel <= w_grant;
      end
      if (w_accept) begin
        r_last_grant <= r_sel;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= CNT_W'(ALU_LAT);
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_rsp_data <= alu_result;
        r_rsp_id   <= r_sel;
      end
    end
  end

  // Registered status outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_start <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_alu_start <= (w_next_state == ST_ISSUE);
      r_rsp_valid <= (w_next_state == ST_RESP);
      r_busy      <= (w_next_state != ST_IDLE);
    end
  end

  assign sel        = r_sel;
  assign alu_start  = r_alu_start;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign busy       = r_busy;
  // Ready completes in the same cycle the consumer accepts the response.
  assign req0_ready = w_accept & ~r_sel;
  assign req1_ready = w_accept &  r_sel;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_data, req1_data;
  logic         sel, alu_start, rsp_valid, rsp_id, rsp_ready, busy;
  logic [W-1:0] alu_in, alu_result, rsp_data;

  int checks = 0;
  int errors = 0;
  logic model_last = 1'b1;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sel(sel), .alu_in(alu_in), .alu_start(alu_start), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // ALU stub: result = in+1 only in the cycle exactly LAT cycles after start.
  logic [4:0] stub_age;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stub_age <= 5'd0;
    else if (alu_start) stub_age <= 5'd1;
    else if (stub_age != 5'd0 && stub_age != 5'd31) stub_age <= stub_age + 5'd1;
  end
  assign alu_result = (stub_age == 5'(LAT)) ? alu_in + 32'd1 : alu_in ^ 32'hBAD0BAD0;

  // Two extra builds with ALU_LAT = 1 and 15 for latency checks.
  logic         x_v0 [2];
  logic         x_v1 [2];
  logic [W-1:0] x_d0 [2];
  logic [W-1:0] x_d1 [2];
  logic         x_rdy0 [2];
  logic         x_rdy1 [2];
  logic         x_sel [2];
  logic [W-1:0] x_in [2];
  logic         x_start [2];
  logic [W-1:0] x_res [2];
  logic         x_rv [2];
  logic         x_rid [2];
  logic [W-1:0] x_rdata [2];
  logic         x_rr [2];
  logic         x_busy [2];

  for (genvar g = 0; g < 2; g++) begin : g_lat
    alu_share_arbiter #(.WIDTH(W), .ALU_LAT(g == 0 ? 1 : 15)) u_x (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(x_v0[g]), .req0_data(x_d0[g]), .req0_ready(x_rdy0[g]),
      .req1_valid(x_v1[g]), .req1_data(x_d1[g]), .req1_ready(x_rdy1[g]),
      .sel(x_sel[g]), .alu_in(x_in[g]), .alu_start(x_start[g]), .alu_result(x_res[g]),
      .rsp_valid(x_rv[g]), .rsp_id(x_rid[g]), .rsp_data(x_rdata[g]),
      .rsp_ready(x_rr[g]), .busy(x_busy[g])
    );
    assign x_res[g] = x_in[g] + 32'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: lone requester wins; on contention, the one not served last.
  function automatic logic pick(input logic v0, input logic v1);
    if (v0 && v1) return ~model_last;
    return v1;
  endfunction

  // One full transaction starting in an idle cycle; leaves the DUT idle.
  task automatic do_txn(input logic v0, input logic v1, input logic [31:0] d0,
                        input logic [31:0] d1, input int stall,
                        input logic eid, input logic [31:0] edata);
    int cyc;
    chk("idle_before", {31'b0, busy}, 32'd0);
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    @(posedge clk); #1;
    chk("issue_start", {31'b0, alu_start}, 32'd1);
    chk("issue_sel", {31'b0, sel}, {31'b0, eid});
    chk("issue_alu_in", alu_in, eid ? d1 : d0);
    chk("issue_busy", {31'b0, busy}, 32'd1);
    for (cyc = 2; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (rsp_valid) break;
      chk("wait_no_start", {31'b0, alu_start}, 32'd0);
    end
    chk("rsp_latency", 32'(cyc), 32'(2 + LAT));
    chk("rsp_id", {31'b0, rsp_id}, {31'b0, eid});
    chk("rsp_data", rsp_data, edata);
    for (int s = 0; s < stall; s++) begin
      chk("stall_no_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
      chk("stall_busy", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_id", {31'b0, rsp_id}, {31'b0, eid});
      chk("stall_data", rsp_data, edata);
      chk("stall_sel", {31'b0, sel}, {31'b0, eid});
    end
    rsp_ready = 1'b1;
    #1;
    chk("ready_pulse", {30'b0, req1_ready, req0_ready}, eid ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("done_valid", {31'b0, rsp_valid}, 32'd0);
    chk("done_busy", {31'b0, busy}, 32'd0);
    chk("done_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    model_last = eid;
  endtask

  typedef struct {
    logic        v0, v1;
    logic [31:0] d0, d1;
    int          stall;
    logic        eid;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 32'h55555555, 32'hDEADBEEF, 0, 1'b0, 32'h55555556};
    vecs[1]  = '{1'b1, 1'b1, 32'h55555555, 32'hDEADBEEF, 0, 1'b1, 32'hDEADBEF0};
    vecs[2]  = '{1'b1, 1'b1, 32'h55555555, 32'hDEADBEEF, 0, 1'b0, 32'h55555556};
    vecs[3]  = '{1'b1, 1'b1, 32'h55555555, 32'hDEADBEEF, 0, 1'b1, 32'hDEADBEF0};
    vecs[4]  = '{1'b1, 1'b0, 32'hAAAAAAAA, 32'h0,        0, 1'b0, 32'hAAAAAAAB};
    vecs[5]  = '{1'b1, 1'b0, 32'h00000001, 32'h0,        5, 1'b0, 32'h00000002};
    vecs[6]  = '{1'b0, 1'b1, 32'h0,        32'hFFFFFFFF, 2, 1'b1, 32'h00000000};
    vecs[7]  = '{1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1, 1'b0, 32'h12345679};
    vecs[8]  = '{1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0, 0, 1'b1, 32'h9ABCDEF1};
    vecs[9]  = '{1'b0, 1'b1, 32'h0,        32'h7FFFFFFF, 0, 1'b1, 32'h80000000};
    vecs[10] = '{1'b1, 1'b1, 32'h0,        32'h0,        0, 1'b0, 32'h00000001};

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 32'h55555555; req1_data = 32'hDEADBEEF;
    for (int k = 0; k < 2; k++) begin
      x_v0[k] = 1'b0; x_v1[k] = 1'b0; x_d0[k] = '0; x_d1[k] = '0; x_rr[k] = 1'b0;
    end

    // Reset held with both requesters valid.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {25'b0, sel, alu_start, rsp_valid, rsp_id, req0_ready, req1_ready, busy}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_in", alu_in, 32'h55555555);
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Directed vector table (back-to-back, no idle gaps between entries).
    for (int i = 0; i < 11; i++)
      do_txn(vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1, vecs[i].stall,
             vecs[i].eid, vecs[i].edata);

    // Reset in the middle of WAIT aborts the transaction.
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 32'h00000003;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_abort_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {27'b0, sel, alu_start, rsp_valid, req0_ready | req1_ready, busy}, 32'd0);
    @(posedge clk); #1;
    chk("abort_hold", {28'b0, alu_start, rsp_valid, req0_ready | req1_ready, busy}, 32'd0);
    req1_valid = 1'b0;
    rst_n = 1'b1;
    model_last = 1'b1;
    @(posedge clk); #1;
    do_txn(1'b1, 1'b1, 32'h00000010, 32'h00000020, 0, 1'b0, 32'h00000011);

    // Randomized traffic checked against the arbitration model.
    for (int i = 0; i < 30; i++) begin
      logic v0, v1, id;
      logic [31:0] d0, d1;
      int st;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      d0 = $urandom; d1 = $urandom;
      st = $urandom_range(0, 3);
      id = pick(v0, v1);
      do_txn(v0, v1, d0, d1, st, id, (id ? d1 : d0) + 32'd1);
    end

    // Latency of the ALU_LAT=1 and ALU_LAT=15 builds.
    for (int k = 0; k < 2; k++) begin
      int lat, cyc;
      lat = (k == 0) ? 1 : 15;
      x_d0[k] = 32'h100 + 32'(k);
      x_v0[k] = 1'b1;
      for (cyc = 1; cyc < 40; cyc++) begin
        @(posedge clk); #1;
        if (x_rv[k]) break;
      end
      chk("lat_first_valid", 32'(cyc), 32'(2 + lat));
      chk("lat_rsp_data", x_rdata[k], 32'h101 + 32'(k));
      x_rr[k] = 1'b1;
      #1;
      chk("lat_ready", {31'b0, x_rdy0[k]}, 32'd1);
      @(posedge clk); #1;
      x_rr[k] = 1'b0; x_v0[k] = 1'b0;
      chk("lat_done_busy", {31'b0, x_busy[k]}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
